// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// hold-until-release semantics and an optional fairness timeout.
module rr_arb4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_v,
    output logic       preempt
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] r_gnt_idx;
    logic [1:0] w_idx_nxt;
    logic       r_preempt;
    logic       w_preempt_nxt;

    logic [3:0] w_others;
    logic [1:0] w_win_all;
    logic [1:0] w_win_oth;
    logic       w_timeout;
    logic [7:0] w_cnt_inc;

    // Scans ptr+1, ptr+2, ptr+3, ptr; the highest-priority hit is assigned last.
    function automatic logic [1:0] f_pick(input logic [3:0] v, input logic [1:0] ptr);
        logic [1:0] idx;
        f_pick = ptr;
        for (int unsigned i = 4; i > 0; i--) begin
            idx = ptr + 2'(i);
            if (v[idx]) begin
                f_pick = idx;
            end
        end
    endfunction

    always_comb begin
        w_others  = req & ~r_gnt;
        w_win_all = f_pick(req, r_ptr);
        w_win_oth = f_pick(w_others, r_ptr);
        w_timeout = (LP_MAX_HOLD != 8'd0) && (r_hold_cnt >= LP_MAX_HOLD) && (|w_others);
        if ((r_hold_cnt != 8'hFF) &&
            ((LP_MAX_HOLD == 8'd0) || (r_hold_cnt < LP_MAX_HOLD))) begin
            w_cnt_inc = r_hold_cnt + 8'd1;
        end else begin
            w_cnt_inc = r_hold_cnt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_gnt_nxt     = r_gnt;
        w_idx_nxt     = r_gnt_idx;
        w_preempt_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_gnt_nxt   = 4'b0001 << w_win_all;
                    w_idx_nxt   = w_win_all;
                    w_ptr_nxt   = w_win_all;
                    w_hold_nxt  = 8'd1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req[r_gnt_idx]) begin
                    if (|w_others) begin
                        w_gnt_nxt  = 4'b0001 << w_win_oth;
                        w_idx_nxt  = w_win_oth;
                        w_ptr_nxt  = w_win_oth;
                        w_hold_nxt = 8'd1;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_gnt_nxt     = 4'b0001 << w_win_oth;
                    w_idx_nxt     = w_win_oth;
                    w_ptr_nxt     = w_win_oth;
                    w_hold_nxt    = 8'd1;
                    w_preempt_nxt = 1'b1;
                end else begin
                    w_hold_nxt = w_cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 2'd3;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_preempt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_idx  <= w_idx_nxt;
            r_preempt  <= w_preempt_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign gnt_v   = (r_state == ST_GRANT);
    assign preempt = r_preempt;

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: two instances (MAX_HOLD=8 and MAX_HOLD=0) share one
// request stream and are compared every cycle against a behavioural model.
module tb_rr_arb4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       v_a, v_b, pre_a, pre_b;

    int n_vec = 0;
    int n_err = 0;

    // Model state per instance: holder (-1 when idle), last winner, cycles served.
    int holder [2];
    int last   [2];
    int served [2];
    bit m_pre  [2];
    int order_q[$];

    always #5 clk = ~clk;

    rr_arb4 #(.MAX_HOLD(8)) u_a (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_v(v_a), .preempt(pre_a)
    );

    rr_arb4 #(.MAX_HOLD(0)) u_b (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_v(v_b), .preempt(pre_b)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int from);
        for (int off = 1; off <= 4; off++) begin
            if (r[(from + off) % 4]) return (from + off) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            holder[i] = -1;
            last[i]   = 3;
            served[i] = 0;
            m_pre[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] others;
        int         maxh;
        for (int i = 0; i < 2; i++) begin
            maxh     = (i == 0) ? 8 : 0;
            m_pre[i] = 1'b0;
            others   = r;
            if (holder[i] < 0) begin
                if (r != 4'b0) begin
                    holder[i] = pick(r, last[i]);
                    last[i]   = holder[i];
                    served[i] = 1;
                end
            end else begin
                others[holder[i]] = 1'b0;
                if (!r[holder[i]]) begin
                    if (others != 4'b0) begin
                        holder[i] = pick(others, last[i]);
                        last[i]   = holder[i];
                        served[i] = 1;
                    end else begin
                        holder[i] = -1;
                        served[i] = 0;
                    end
                end else if (maxh != 0 && served[i] >= maxh && others != 4'b0) begin
                    holder[i] = pick(others, last[i]);
                    last[i]   = holder[i];
                    served[i] = 1;
                    m_pre[i]  = 1'b1;
                end else begin
                    served[i]++;
                end
            end
        end
    endtask

    // Packed as {preempt, gnt_v, gnt_idx, gnt}.
    function automatic logic [7:0] exp_vec(input int i);
        if (holder[i] < 0) return {m_pre[i], 7'b0};
        return {m_pre[i], 1'b1, 2'(holder[i]), 4'(1 << holder[i])};
    endfunction

    task automatic compare(input string tag);
        chk({tag, "_a"}, {pre_a, v_a, idx_a, gnt_a}, exp_vec(0));
        chk({tag, "_b"}, {pre_b, v_b, idx_b, gnt_b}, exp_vec(1));
    endtask

    task automatic cycle(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        compare(tag);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare("async_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        int         exp_order[6] = '{0, 1, 2, 3, 0, 1};

        rst = 1'b1;
        req = 4'b1111;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare("in_rst");
        @(negedge clk);
        rst = 1'b0;

        cycle(4'b1111, "first");
        chk("first_gnt", {4'b0, gnt_a}, 8'h01);
        order_q.push_back(int'(idx_a));

        for (int n = 0; n < 12; n++) begin
            r = 4'b1111;
            if (holder[0] >= 0 && served[0] >= 2) r[holder[0]] = 1'b0;
            cycle(r, "rr");
            chk("rr_nobubble", {7'b0, v_a}, 8'h01);
            if (int'(idx_a) != order_q[order_q.size() - 1]) order_q.push_back(int'(idx_a));
        end
        for (int k = 0; k < 6; k++) begin
            chk("rr_order", 8'(order_q[k]), 8'(exp_order[k]));
        end

        async_reset();

        for (int n = 0; n < 34; n++) cycle(4'b0011, "timeout");
        for (int n = 0; n < 20; n++) cycle(4'b0100, "lone");
        repeat (2) cycle(4'b0000, "lone_off");
        for (int n = 0; n < 31; n++) cycle(4'b1001, "nohold");
        repeat (3) cycle(4'b1000, "nohold_drop");
        repeat (2) cycle(4'b0000, "idle");

        repeat (3) cycle(4'b0100, "rot_g2");
        repeat (2) cycle(4'b0000, "rot_idle");
        cycle(4'b0101, "rot");
        chk("rot_mem", {4'b0, gnt_a}, 8'h01);

        r = 4'b0;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                0:       r = 4'($urandom);
                1:       r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
                default: ;
            endcase
            cycle(r, "rand");
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
